// File: rtl/pwm_ramp_sequencer.sv
// pwm_ramp_sequencer
// Conversion sequencer for the PWM-ramp ADC. It selects analog mux channels
// round-robin from an enable mask and lets each input settle while the ramp
// is held at zero. It then runs the ramp until the comparator rises or the
// ramp wraps, and presents one tagged result per conversion on a
// valid/ready port.
//
// Ports:
//   clk_i, rst_i        clock, synchronous active-high reset
//   enable_i            run continuous round-robin scans while high
//   ch_mask_i           channel enable mask, used when picking a channel
//   lvds_i              comparator output, already synchronized to clk_i
//   pwm_dc_i            current ramp duty code
//   ramp_wrap_i         one-cycle pulse when the ramp passes full scale
//   mux_sel_o           analog mux select
//   ramp_clear_o        holds the ramp counter at zero
//   ramp_run_o          enables the ramp
//   busy_o              high whenever the sequencer is not idle
//   result_valid_o/_ready_i, result_ch_o, result_data_o, result_overrange_o
//                       result stream (channel, code, wrap-without-edge flag)
module pwm_ramp_sequencer #(
   parameter int NBITS         = 8,
   parameter int NCH           = 4,
   parameter int SETTLE_CYCLES = 16,
   localparam int CW           = $clog2(NCH)
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             enable_i,
   input  logic [NCH-1:0]   ch_mask_i,
   input  logic             lvds_i,
   input  logic [NBITS-1:0] pwm_dc_i,
   input  logic             ramp_wrap_i,
   output logic [CW-1:0]    mux_sel_o,
   output logic             ramp_clear_o,
   output logic             ramp_run_o,
   output logic             busy_o,
   output logic             result_valid_o,
   input  logic             result_ready_i,
   output logic [CW-1:0]    result_ch_o,
   output logic [NBITS-1:0] result_data_o,
   output logic             result_overrange_o
);

   localparam logic [2:0] ST_IDLE    = 3'd0;
   localparam logic [2:0] ST_SELECT  = 3'd1;
   localparam logic [2:0] ST_SETTLE  = 3'd2;
   localparam logic [2:0] ST_CONVERT = 3'd3;
   localparam logic [2:0] ST_OUTPUT  = 3'd4;

   localparam int CNTW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
   localparam logic [CNTW-1:0] SETTLE_LOAD = CNTW'(SETTLE_CYCLES - 1);

   logic [2:0]       state_q, state_d;
   logic [CW-1:0]    ptr_q, ptr_d;
   logic [CNTW-1:0]  cnt_q, cnt_d;
   logic             lvds_q, lvds_d;
   logic [CW-1:0]    mux_sel_q, mux_sel_d;
   logic             ramp_clear_q, ramp_clear_d;
   logic             ramp_run_q, ramp_run_d;
   logic             busy_q, busy_d;
   logic             valid_q, valid_d;
   logic [CW-1:0]    ch_q, ch_d;
   logic [NBITS-1:0] data_q, data_d;
   logic             ovr_q, ovr_d;

   logic             found;
   logic [CW-1:0]    next_ch;
   logic [CW-1:0]    cand;
   logic             lvds_edge;

   // Round-robin channel search. Candidates are visited from the farthest
   // offset down to pointer+1, so the last hit written is the nearest
   // enabled channel after the one converted most recently.
   always_comb begin
      found   = 1'b0;
      next_ch = '0;
      cand    = '0;
      for (int i = NCH; i >= 1; i--) begin
         cand = CW'((int'(ptr_q) + i) % NCH);
         if (ch_mask_i[cand]) begin
            found   = 1'b1;
            next_ch = cand;
         end
      end
   end

   // Sequencer next-state logic. Ramp control and busy are derived from the
   // next state so the registered outputs line up with the state they
   // describe; a comparator that is already high on entry to CONVERT gives
   // no edge because lvds_q is tracked in every state.
   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      cnt_d     = cnt_q;
      lvds_d    = lvds_i;
      mux_sel_d = mux_sel_q;
      valid_d   = valid_q;
      ch_d      = ch_q;
      data_d    = data_q;
      ovr_d     = ovr_q;
      lvds_edge = lvds_i && !lvds_q;

      case (state_q)
         ST_IDLE: begin
            if (enable_i) state_d = ST_SELECT;
         end
         ST_SELECT: begin
            if (enable_i && found) begin
               mux_sel_d = next_ch;
               ptr_d     = next_ch;
               cnt_d     = SETTLE_LOAD;
               state_d   = ST_SETTLE;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_SETTLE: begin
            if (cnt_q == '0) state_d = ST_CONVERT;
            else             cnt_d   = cnt_q - 1'b1;
         end
         ST_CONVERT: begin
            if (lvds_edge || ramp_wrap_i) begin
               if (lvds_edge) begin
                  data_d = pwm_dc_i;
                  ovr_d  = 1'b0;
               end else begin
                  data_d = '1;
                  ovr_d  = 1'b1;
               end
               ch_d    = mux_sel_q;
               valid_d = 1'b1;
               state_d = ST_OUTPUT;
            end
         end
         ST_OUTPUT: begin
            if (valid_q && result_ready_i) begin
               valid_d = 1'b0;
               state_d = enable_i ? ST_SELECT : ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      ramp_run_d   = (state_d == ST_CONVERT);
      ramp_clear_d = !ramp_run_d;
      busy_d       = (state_d != ST_IDLE);
   end

   // State and output registers; reset discards any pending result and
   // rewinds the pointer so the next scan starts at channel 0.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q      <= ST_IDLE;
         ptr_q        <= CW'(NCH - 1);
         cnt_q        <= '0;
         lvds_q       <= 1'b0;
         mux_sel_q    <= '0;
         ramp_clear_q <= 1'b1;
         ramp_run_q   <= 1'b0;
         busy_q       <= 1'b0;
         valid_q      <= 1'b0;
         ch_q         <= '0;
         data_q       <= '0;
         ovr_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         ptr_q        <= ptr_d;
         cnt_q        <= cnt_d;
         lvds_q       <= lvds_d;
         mux_sel_q    <= mux_sel_d;
         ramp_clear_q <= ramp_clear_d;
         ramp_run_q   <= ramp_run_d;
         busy_q       <= busy_d;
         valid_q      <= valid_d;
         ch_q         <= ch_d;
         data_q       <= data_d;
         ovr_q        <= ovr_d;
      end
   end

   assign mux_sel_o          = mux_sel_q;
   assign ramp_clear_o       = ramp_clear_q;
   assign ramp_run_o         = ramp_run_q;
   assign busy_o             = busy_q;
   assign result_valid_o     = valid_q;
   assign result_ch_o        = ch_q;
   assign result_data_o      = data_q;
   assign result_overrange_o = ovr_q;

endmodule
